// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW traceback slice: path codes, FSM states,
// default geometry and the boundary-forcing rule applied to every beat.
package dtw_pkg;

    localparam int DEFAULT_LANES = 6;
    localparam int DEFAULT_IW    = 5;

    localparam logic [1:0] PATH_DIAG = 2'b00;
    localparam logic [1:0] PATH_UP   = 2'b01;
    localparam logic [1:0] PATH_LEFT = 2'b10;
    localparam logic [1:0] PATH_NONE = 2'b11;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TRACE = 1'b1
    } state_e;

    typedef struct packed {
        logic [1:0] step;
        logic       last;
        logic       err;
    } beat_flags_t;

    // An unwritten code ends the walk before edge forcing is considered.
    function automatic beat_flags_t resolve_step(input logic t_zero,
                                                 input logic r_zero,
                                                 input logic [1:0] code);
        beat_flags_t f;
        f.step = code;
        f.last = 1'b0;
        f.err  = 1'b0;
        if (t_zero && r_zero) begin
            f.last = 1'b1;
        end else if (code == PATH_NONE) begin
            f.last = 1'b1;
            f.err  = 1'b1;
        end else if (t_zero) begin
            f.step = PATH_LEFT;
        end else if (r_zero) begin
            f.step = PATH_UP;
        end
        return f;
    endfunction

endpackage

// File: rtl/dtw_pathmap.sv
// 2^IW x 2^IW map of 2-bit path codes with LANES write ports and one
// combinational read port that sees this cycle's writes.
module dtw_pathmap
    import dtw_pkg::*;
#(
    parameter int LANES = DEFAULT_LANES,
    parameter int IW    = DEFAULT_IW
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  we,
    input  logic [LANES-1:0]      i_pvalid,
    input  logic [2*LANES-1:0]    i_path,
    input  logic [IW*LANES-1:0]   i_tindex,
    input  logic [IW*LANES-1:0]   i_rindex,
    input  logic [IW-1:0]         rd_t,
    input  logic [IW-1:0]         rd_r,
    output logic [1:0]            rd_code
);

    localparam int CELLS = 1 << (2 * IW);

    logic [1:0] map_q [CELLS];
    logic [1:0] map_d [CELLS];

    // Lanes are applied in ascending order so the highest lane wins a collision.
    always_comb begin
        map_d = map_q;
        if (we) begin
            for (int k = 0; k < LANES; k++) begin
                if (i_pvalid[LANES-1-k]) begin
                    map_d[{i_tindex[IW*(LANES-k)-1 -: IW],
                           i_rindex[IW*(LANES-k)-1 -: IW]}] = i_path[2*(LANES-k)-1 -: 2];
                end
            end
        end
    end

    assign rd_code = map_d[{rd_t, rd_r}];

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < CELLS; i++) begin
                map_q[i] <= PATH_NONE;
            end
        end else begin
            map_q <= map_d;
        end
    end

endmodule

// File: rtl/dtw_traceback.sv
// DTW path traceback: captures path codes, then walks back from (tlast, rlast)
// to (0,0) one registered beat per cycle. DTW_TB_PATHLEN_EN adds o_plen.
module dtw_traceback
    import dtw_pkg::*;
#(
    parameter int LANES = DEFAULT_LANES,
    parameter int IW    = DEFAULT_IW
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  ena,
    input  logic [LANES-1:0]      i_pvalid,
    input  logic [2*LANES-1:0]    i_path,
    input  logic [IW*LANES-1:0]   i_tindex,
    input  logic [IW*LANES-1:0]   i_rindex,
    input  logic                  start,
    input  logic [IW-1:0]         i_tlast,
    input  logic [IW-1:0]         i_rlast,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [IW-1:0]         o_t,
    output logic [IW-1:0]         o_r,
    output logic [1:0]            o_step,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_err
`ifdef DTW_TB_PATHLEN_EN
    ,
    output logic [IW:0]           o_plen
`endif
);

    state_e         state_q, state_d;
    logic           o_valid_q, o_valid_d;
    logic [IW-1:0]  o_t_q, o_t_d;
    logic [IW-1:0]  o_r_q, o_r_d;
    logic [1:0]     o_step_q, o_step_d;
    logic           o_last_q, o_last_d;
    logic           o_err_q, o_err_d;
`ifdef DTW_TB_PATHLEN_EN
    logic [IW:0]    o_plen_q, o_plen_d;
`endif

    logic           map_we;
    logic           load;
    logic           accept;
    logic [IW-1:0]  rd_t;
    logic [IW-1:0]  rd_r;
    logic [1:0]     rd_code;
    beat_flags_t    flags;

    dtw_pathmap #(
        .LANES (LANES),
        .IW    (IW)
    ) u_pathmap (
        .clk      (clk),
        .nrst     (nrst),
        .we       (map_we),
        .i_pvalid (i_pvalid),
        .i_path   (i_path),
        .i_tindex (i_tindex),
        .i_rindex (i_rindex),
        .rd_t     (rd_t),
        .rd_r     (rd_r),
        .rd_code  (rd_code)
    );

    // The read address is the cell the next beat will describe.
    always_comb begin
        map_we = 1'b0;
        load   = 1'b0;
        accept = 1'b0;
        rd_t   = o_t_q;
        rd_r   = o_r_q;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    map_we = 1'b1;
                    if (start) begin
                        load = 1'b1;
                        rd_t = i_tlast;
                        rd_r = i_rlast;
                    end
                end
                TRACE: begin
                    if (o_valid_q && i_ready) begin
                        accept = 1'b1;
                        if (!o_last_q) begin
                            load = 1'b1;
                            case (o_step_q)
                                PATH_DIAG: begin
                                    rd_t = o_t_q - IW'(1);
                                    rd_r = o_r_q - IW'(1);
                                end
                                PATH_UP:   rd_t = o_t_q - IW'(1);
                                PATH_LEFT: rd_r = o_r_q - IW'(1);
                                default: ;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        o_valid_d = o_valid_q;
        o_t_d     = o_t_q;
        o_r_d     = o_r_q;
        o_step_d  = o_step_q;
        o_last_d  = o_last_q;
        o_err_d   = o_err_q;
`ifdef DTW_TB_PATHLEN_EN
        o_plen_d  = o_plen_q;
`endif
        flags = resolve_step(rd_t == '0, rd_r == '0, rd_code);

        if (ena && state_q == IDLE && start) begin
            state_d = TRACE;
            o_err_d = 1'b0;
`ifdef DTW_TB_PATHLEN_EN
            o_plen_d = '0;
`endif
        end

        if (accept) begin
`ifdef DTW_TB_PATHLEN_EN
            o_plen_d = o_plen_q + (IW+1)'(1);
`endif
            if (o_last_q) begin
                state_d   = IDLE;
                o_valid_d = 1'b0;
                o_last_d  = 1'b0;
            end
        end

        if (load) begin
            o_valid_d = 1'b1;
            o_t_d     = rd_t;
            o_r_d     = rd_r;
            o_step_d  = flags.step;
            o_last_d  = flags.last;
            o_err_d   = o_err_d | flags.err;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= IDLE;
            o_valid_q <= 1'b0;
            o_t_q     <= '0;
            o_r_q     <= '0;
            o_step_q  <= 2'b00;
            o_last_q  <= 1'b0;
            o_err_q   <= 1'b0;
`ifdef DTW_TB_PATHLEN_EN
            o_plen_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            o_valid_q <= o_valid_d;
            o_t_q     <= o_t_d;
            o_r_q     <= o_r_d;
            o_step_q  <= o_step_d;
            o_last_q  <= o_last_d;
            o_err_q   <= o_err_d;
`ifdef DTW_TB_PATHLEN_EN
            o_plen_q  <= o_plen_d;
`endif
        end
    end

    assign o_valid = o_valid_q;
    assign o_t     = o_t_q;
    assign o_r     = o_r_q;
    assign o_step  = o_step_q;
    assign o_last  = o_last_q;
    assign o_err   = o_err_q;
    assign o_busy  = (state_q != IDLE);
`ifdef DTW_TB_PATHLEN_EN
    assign o_plen  = o_plen_q;
`endif

endmodule

// File: tb/tb_dtw_traceback.sv
// Scoreboard bench for dtw_traceback: scenarios push expected beats, a
// monitor pops and compares each accepted beat.
module tb_dtw_traceback;
    import dtw_pkg::*;

    localparam int LANES = 6;
    localparam int IW    = 5;

    logic                clk = 1'b0;
    logic                nrst;
    logic                ena;
    logic [LANES-1:0]    i_pvalid;
    logic [2*LANES-1:0]  i_path;
    logic [IW*LANES-1:0] i_tindex;
    logic [IW*LANES-1:0] i_rindex;
    logic                start;
    logic [IW-1:0]       i_tlast;
    logic [IW-1:0]       i_rlast;
    logic                o_valid;
    logic                i_ready;
    logic [IW-1:0]       o_t;
    logic [IW-1:0]       o_r;
    logic [1:0]          o_step;
    logic                o_last;
    logic                o_busy;
    logic                o_err;
`ifdef DTW_TB_PATHLEN_EN
    logic [IW:0]         o_plen;
`endif

    typedef struct packed {
        logic [IW-1:0] t;
        logic [IW-1:0] r;
        logic [1:0]    step;
        logic          last;
    } beat_t;

    beat_t sb[$];
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    dtw_traceback #(.LANES(LANES), .IW(IW)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .ena      (ena),
        .i_pvalid (i_pvalid),
        .i_path   (i_path),
        .i_tindex (i_tindex),
        .i_rindex (i_rindex),
        .start    (start),
        .i_tlast  (i_tlast),
        .i_rlast  (i_rlast),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_t      (o_t),
        .o_r      (o_r),
        .o_step   (o_step),
        .o_last   (o_last),
        .o_busy   (o_busy),
        .o_err    (o_err)
`ifdef DTW_TB_PATHLEN_EN
        ,
        .o_plen   (o_plen)
`endif
    );

    function automatic beat_t mk(input int t, input int r, input logic [1:0] s, input logic l);
        beat_t b;
        b.t    = IW'(t);
        b.r    = IW'(r);
        b.step = s;
        b.last = l;
        return b;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        i_pvalid = '0;
        i_path   = '0;
        i_tindex = '0;
        i_rindex = '0;
    endtask

    task automatic set_lane(input int k, input int t, input int r, input logic [1:0] code);
        i_pvalid[LANES-1-k]              = 1'b1;
        i_path[2*(LANES-k)-1 -: 2]       = code;
        i_tindex[IW*(LANES-k)-1 -: IW]   = IW'(t);
        i_rindex[IW*(LANES-k)-1 -: IW]   = IW'(r);
    endtask

    task automatic drive_start(input int t, input int r);
        i_tlast = IW'(t);
        i_rlast = IW'(r);
        start   = 1'b1;
    endtask

    // mode 0: i_ready held high; mode 1: i_ready toggles 1,0,1,0...
    task automatic wait_idle(input int budget, input int mode, output int vcycles, output bit ok);
        vcycles = 0;
        ok      = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (!o_busy) begin
                ok = 1'b1;
                break;
            end
            if (o_valid) vcycles++;
            i_ready = (mode == 0) ? 1'b1 : ((c % 2) == 0);
            next_cycle();
        end
        if (!o_busy) ok = 1'b1;
        i_ready = 1'b0;
    endtask

    // Monitor: every accepted beat is checked against the scoreboard, and a
    // stalled beat must keep its payload until it is accepted.
    beat_t got, exp_b, held;
    bit    hold;
    initial begin
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (nrst !== 1'b1) begin
                hold = 1'b0;
            end else begin
                got = {o_t, o_r, o_step, o_last};
                if (hold) begin
                    total++;
                    if (o_valid !== 1'b1 || got !== held) begin
                        bad++;
                        $display("[TB] FAIL stall_hold: got valid=%b t=%0d r=%0d step=%b last=%b, required valid=1 t=%0d r=%0d step=%b last=%b",
                                 o_valid, got.t, got.r, got.step, got.last, held.t, held.r, held.step, held.last);
                    end
                end
                if (o_valid === 1'b1 && i_ready === 1'b1 && ena === 1'b1) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL beat: got t=%0d r=%0d step=%b last=%b, required no beat",
                                 got.t, got.r, got.step, got.last);
                    end else begin
                        exp_b = sb.pop_front();
                        if (got !== exp_b) begin
                            bad++;
                            $display("[TB] FAIL beat: got t=%0d r=%0d step=%b last=%b, required t=%0d r=%0d step=%b last=%b",
                                     got.t, got.r, got.step, got.last, exp_b.t, exp_b.r, exp_b.step, exp_b.last);
                        end
                    end
                end
                hold = (o_valid === 1'b1) && !(i_ready === 1'b1 && ena === 1'b1);
                held = got;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic test_reset();
        nrst = 1'b0;
        next_cycle();
        next_cycle();
        total++;
        if ({o_valid, o_busy, o_last, o_err} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_flags: got valid=%b busy=%b last=%b err=%b, required all 0",
                     o_valid, o_busy, o_last, o_err);
        end
        total++;
        if ({o_t, o_r, o_step} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_payload: got t=%0d r=%0d step=%b, required 0 0 00", o_t, o_r, o_step);
        end
        nrst = 1'b1;
        next_cycle();
    endtask

    task automatic test_diag();
        int vc;
        bit ok;
        for (int k = 0; k < 4; k++) set_lane(k, k, k, PATH_DIAG);
        next_cycle();
        clear_lanes();
        sb.push_back(mk(3, 3, PATH_DIAG, 1'b0));
        sb.push_back(mk(2, 2, PATH_DIAG, 1'b0));
        sb.push_back(mk(1, 1, PATH_DIAG, 1'b0));
        sb.push_back(mk(0, 0, PATH_DIAG, 1'b1));
        drive_start(3, 3);
        next_cycle();
        start = 1'b0;
        total++;
        if (o_busy !== 1'b1 || o_valid !== 1'b1 || o_t !== 5'd3 || o_r !== 5'd3) begin
            bad++;
            $display("[TB] FAIL diag_first: got busy=%b valid=%b t=%0d r=%0d, required 1 1 3 3",
                     o_busy, o_valid, o_t, o_r);
        end
        wait_idle(40, 0, vc, ok);
        total++;
        if (!ok || vc != 4) begin
            bad++;
            $display("[TB] FAIL diag_cycles: got done=%0d valid_cycles=%0d, required 1 4", ok, vc);
        end
        total++;
        if (o_valid !== 1'b0 || o_err !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL diag_end: got valid=%b err=%b pending=%0d, required 0 0 0",
                     o_valid, o_err, sb.size());
        end
`ifdef DTW_TB_PATHLEN_EN
        total++;
        if (o_plen !== 6'd4) begin
            bad++;
            $display("[TB] FAIL diag_plen: got %0d, required 4", o_plen);
        end
`endif
    endtask

    task automatic test_ready_toggle();
        int vc;
        bit ok;
        set_lane(0, 2, 2, PATH_UP);
        set_lane(1, 1, 2, PATH_LEFT);
        set_lane(2, 1, 1, PATH_DIAG);
        sb.push_back(mk(2, 2, PATH_UP, 1'b0));
        sb.push_back(mk(1, 2, PATH_LEFT, 1'b0));
        sb.push_back(mk(1, 1, PATH_DIAG, 1'b0));
        sb.push_back(mk(0, 0, PATH_DIAG, 1'b1));
        drive_start(2, 2);
        next_cycle();
        start = 1'b0;
        clear_lanes();
        total++;
        if (o_t !== 5'd2 || o_r !== 5'd2 || o_step !== PATH_UP) begin
            bad++;
            $display("[TB] FAIL same_cycle_write: got t=%0d r=%0d step=%b, required 2 2 01", o_t, o_r, o_step);
        end
        wait_idle(40, 1, vc, ok);
        total++;
        if (!ok || vc != 7 || sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL toggle_end: got done=%0d valid_cycles=%0d pending=%0d, required 1 7 0",
                     ok, vc, sb.size());
        end
    endtask

    task automatic test_unwritten();
        int vc;
        bit ok;
        set_lane(0, 5, 5, PATH_DIAG);
        next_cycle();
        clear_lanes();
        sb.push_back(mk(5, 5, PATH_DIAG, 1'b0));
        sb.push_back(mk(4, 4, PATH_NONE, 1'b1));
        drive_start(5, 5);
        next_cycle();
        start = 1'b0;
        wait_idle(40, 0, vc, ok);
        total++;
        if (!ok || o_err !== 1'b1 || sb.size() != 0 || o_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL unwritten_err: got done=%0d err=%b pending=%0d busy=%b, required 1 1 0 0",
                     ok, o_err, sb.size(), o_busy);
        end
    endtask

    task automatic test_boundary();
        int vc;
        bit ok;
        set_lane(0, 0, 3, PATH_DIAG);
        set_lane(1, 0, 2, PATH_DIAG);
        set_lane(2, 0, 1, PATH_DIAG);
        set_lane(3, 2, 0, PATH_DIAG);
        set_lane(4, 1, 0, PATH_DIAG);
        next_cycle();
        clear_lanes();
        sb.push_back(mk(0, 3, PATH_LEFT, 1'b0));
        sb.push_back(mk(0, 2, PATH_LEFT, 1'b0));
        sb.push_back(mk(0, 1, PATH_LEFT, 1'b0));
        sb.push_back(mk(0, 0, PATH_DIAG, 1'b1));
        drive_start(0, 3);
        next_cycle();
        start = 1'b0;
        total++;
        if (o_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL err_clear: got %b, required 0", o_err);
        end
        wait_idle(40, 0, vc, ok);
        total++;
        if (!ok || vc != 4) begin
            bad++;
            $display("[TB] FAIL edge_t0: got done=%0d valid_cycles=%0d, required 1 4", ok, vc);
        end
        sb.push_back(mk(2, 0, PATH_UP, 1'b0));
        sb.push_back(mk(1, 0, PATH_UP, 1'b0));
        sb.push_back(mk(0, 0, PATH_DIAG, 1'b1));
        drive_start(2, 0);
        next_cycle();
        start = 1'b0;
        total++;
        if (o_busy !== 1'b1 || o_t !== 5'd2 || o_r !== 5'd0 || o_step !== PATH_UP) begin
            bad++;
            $display("[TB] FAIL restart: got busy=%b t=%0d r=%0d step=%b, required 1 2 0 01",
                     o_busy, o_t, o_r, o_step);
        end
        wait_idle(40, 0, vc, ok);
        total++;
        if (!ok || vc != 3 || sb.size() != 0 || o_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL edge_r0: got done=%0d valid_cycles=%0d pending=%0d err=%b, required 1 3 0 0",
                     ok, vc, sb.size(), o_err);
        end
    endtask

    task automatic test_collision();
        int vc;
        bit ok;
        set_lane(0, 7, 7, PATH_UP);
        set_lane(5, 7, 7, PATH_LEFT);
        next_cycle();
        clear_lanes();
        sb.push_back(mk(7, 7, PATH_LEFT, 1'b0));
        sb.push_back(mk(7, 6, PATH_NONE, 1'b1));
        i_ready = 1'b0;
        drive_start(7, 7);
        next_cycle();
        start = 1'b0;
        total++;
        if (o_step !== PATH_LEFT) begin
            bad++;
            $display("[TB] FAIL collision: got step=%b, required 10", o_step);
        end
        for (int c = 0; c < 3; c++) begin
            set_lane(2, 7, 6, PATH_LEFT);
            set_lane(3, 7, 7, PATH_DIAG);
            next_cycle();
        end
        clear_lanes();
        ena     = 1'b0;
        i_ready = 1'b1;
        next_cycle();
        next_cycle();
        total++;
        if (o_valid !== 1'b1 || o_t !== 5'd7 || o_r !== 5'd7) begin
            bad++;
            $display("[TB] FAIL ena_stall: got valid=%b t=%0d r=%0d, required 1 7 7", o_valid, o_t, o_r);
        end
        ena = 1'b1;
        wait_idle(40, 0, vc, ok);
        total++;
        if (!ok || o_err !== 1'b1 || sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL trace_write_ignored: got done=%0d err=%b pending=%0d, required 1 1 0",
                     ok, o_err, sb.size());
        end
    endtask

    task automatic test_reset_mid_trace();
        int vc;
        bit ok;
        i_ready = 1'b0;
        drive_start(3, 3);
        next_cycle();
        start = 1'b0;
        next_cycle();
        nrst = 1'b0;
        next_cycle();
        total++;
        if ({o_valid, o_busy, o_last, o_err} !== 4'b0000 || {o_t, o_r, o_step} !== '0) begin
            bad++;
            $display("[TB] FAIL mid_reset: got valid=%b busy=%b last=%b err=%b t=%0d r=%0d step=%b, required all 0",
                     o_valid, o_busy, o_last, o_err, o_t, o_r, o_step);
        end
        nrst = 1'b1;
        sb.push_back(mk(3, 3, PATH_NONE, 1'b1));
        drive_start(3, 3);
        next_cycle();
        start = 1'b0;
        wait_idle(40, 0, vc, ok);
        total++;
        if (!ok || vc != 1 || o_err !== 1'b1 || sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL map_cleared: got done=%0d valid_cycles=%0d err=%b pending=%0d, required 1 1 1 0",
                     ok, vc, o_err, sb.size());
        end
        sb.push_back(mk(0, 0, PATH_NONE, 1'b1));
        drive_start(0, 0);
        next_cycle();
        start = 1'b0;
        wait_idle(40, 0, vc, ok);
        total++;
        if (!ok || o_err !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL origin_none: got done=%0d err=%b pending=%0d, required 1 0 0",
                     ok, o_err, sb.size());
        end
    endtask

    initial begin
        nrst    = 1'b0;
        ena     = 1'b1;
        start   = 1'b0;
        i_ready = 1'b0;
        i_tlast = '0;
        i_rlast = '0;
        clear_lanes();
        $display("[TB] starting dtw_traceback bench");
        test_reset();
        test_diag();
        test_ready_toggle();
        test_unwritten();
        test_boundary();
        test_collision();
        test_reset_mid_trace();
        next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dtw_traceback.md
# dtw_traceback

DTW path traceback unit placed after the 6-PE systolic array. It captures the per-cell 2-bit path codes the array produces into a 32x32 path map. On command, it walks the map backward from the final cell (tlast, rlast) to the origin (0,0) and emits one path step per beat on a valid/ready stream. It is the consumer of the array's path output: the array writes cells forward, and this block reads them in reverse.

## Interface
Parameters:
- LANES, 6, number of PE lanes captured per cycle
- IW, 5, index width; map is 2^IW x 2^IW cells

Ports:
- clk  in  1  clock; all logic on rising edge
- nrst  in  1  reset, synchronous, active-low
- ena  in  1  global enable; low freezes all state and outputs
- i_pvalid  in  LANES  per-lane write valid; lane 0 is MSB
- i_path  in  2*LANES  path codes, lane k at [2*LANES-1-2k -: 2]
- i_tindex  in  IW*LANES  T index per lane, same packing, IW bits each
- i_rindex  in  IW*LANES  R index per lane, same packing
- start  in  1  begin traceback (sampled in IDLE only)
- i_tlast  in  IW  final T index
- i_rlast  in  IW  final R index
- o_valid  out  1  step beat valid
- i_ready  in  1  downstream accepts beat
- o_t  out  IW  T index of current cell
- o_r  out  IW  R index of current cell
- o_step  out  2  code read at (o_t, o_r), after boundary forcing
- o_last  out  1  beat is the origin cell or the error-terminating beat
- o_busy  out  1  state != IDLE
- o_err  out  1  sticky: code 11 hit at a non-origin cell; cleared on next accepted start

## Operation
- Path codes: 00 = diagonal (t-1, r-1); 01 = up (t-1, r); 10 = left (t, r-1); 11 = unwritten/invalid.
- Map cells reset to 11.
- FSM states:
  - IDLE: each cycle with ena=1, every lane with i_pvalid=1 writes its i_path to the map at (tindex, rindex).
    - Same-cell collision within one cycle: the higher lane number wins (lane 5 over lane 0).
    - start=1 → load cur=(i_tlast, i_rlast), clear o_err, go to TRACE.
  - TRACE: all writes are ignored and start is ignored.
    - Beat = {cur, code(cur)}, registered. When o_valid & i_ready, cur advances per o_step.
    - Boundary forcing: t==0 and r!=0 → step forced 10; r==0 and t!=0 → forced 01; t==0 and r==0 → o_last=1 and step reported as stored.
    - Code 11 at a non-origin cell → o_err=1, o_last=1; that beat terminates the walk.
    - Accepted beat with o_last=1 → IDLE.
- o_valid holds with stable payload while i_ready=0.
- ena=0 during TRACE stalls everything, including handshake acceptance.
- nrst=0 at any time: FSM to IDLE, map cleared to 11, and all outputs return to reset values next edge. The in-flight walk is discarded.

## Timing
- Reset values: o_valid=0, o_t=0, o_r=0, o_step=0, o_last=0, o_busy=0, o_err=0.
- Write latency: cell written at the edge where i_pvalid is sampled. A start on the cycle after the last write sees that write.
- start sampled at edge N → o_busy=1 and o_valid=1 with the first beat after edge N.
- Throughput is one beat per cycle under continuous i_ready. A path of L cells takes L cycles from first o_valid.
- Last beat accepted at edge M → o_valid=0 and o_busy=0 after edge M. A new start is accepted at edge M+1.
- A start in the same cycle as writes: writes from that cycle are committed first, then TRACE begins.

## Configuration
- DTW_TB_PATHLEN_EN defined: adds output o_plen (IW+1 bits).
  - Cleared on accepted start; increments on each accepted beat.
  - Final value is valid from the edge that accepts the o_last beat until the next start. Maximum value is 2^(IW+1)-1.
- Undefined: port and counter absent; all other behaviour is identical.

## Structure
- Shared package dtw_pkg holds:
  - path code constants PATH_DIAG=2'b00, PATH_UP=2'b01, PATH_LEFT=2'b10, PATH_NONE=2'b11
  - the FSM state enum {IDLE, TRACE}
  - default IW and LANES
- Sub-module dtw_pathmap: 2^(2*IW) x 2-bit flop array with LANES write ports (lane-priority resolve), one combinational read port, and synchronous reset to PATH_NONE.
- Top level holds the FSM, cursor, and output registers.

## Test plan
- Write diagonal-only codes on (k,k) for k=0..3 → start with tlast=3, rlast=3 → beats (3,3,00), (2,2,00), (1,1,00), (0,0,xx, last), 4 cycles, o_err=0.
- Map with (2,2)=01, (1,2)=10, (1,1)=00, i_ready toggling 1,0,1,0 → beats (2,2), (1,2), (1,1), (0,0); payload stable while i_ready=0.
- Unwritten cell: start at (5,5) with (5,5)=00 and (4,4)=11 → second beat (4,4,11), o_last=1, o_err=1; next start clears o_err.
- Boundary forcing: start at (0,3) with stored codes 00 → steps 10, 10, 10, then (0,0) last; start at (2,0) → steps 01, 01, then last.
- Lane collision: lanes 0 and 5 both write (7,7) with 01 and 10 respectively → traceback from (7,7) reports 10. Writes asserted during TRACE leave the map unchanged.
- nrst low mid-TRACE for 1 cycle → o_valid=0, o_busy=0 next edge; immediate start reads PATH_NONE everywhere. With DTW_TB_PATHLEN_EN, the first scenario yields o_plen=4.
